// File: rtl/mac_tile_pkg.sv
// mac_tile_pkg: shared definitions for the dual-dataflow MAC tile.
//   state_e           tile FSM states
//   INST_LOAD/EXEC/FLUSH  bit positions inside the 3-bit instruction bus
//   MODE_WS/MODE_OS   encodings of the mode input
package mac_tile_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WS_LOADED = 2'd1,
    OS_ACC    = 2'd2,
    OS_DRAIN  = 2'd3
  } state_e;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_FLUSH = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_sat.sv
// mac_sat: combinational sum_o = a_i * b_i + c_i.
//   a_i    unsigned activation (bw bits)
//   b_i    two's-complement weight (bw bits)
//   c_i    signed addend (psum_bw bits)
//   sum_o  signed result (psum_bw bits)
//   ovf_o  result was clamped (only with MAC_TILE_SAT_EN)
// Build option MAC_TILE_SAT_EN: saturate to the signed psum_bw range instead
// of wrapping.
module mac_sat #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic        [bw-1:0]      a_i,
  input  logic signed [bw-1:0]      b_i,
  input  logic signed [psum_bw-1:0] c_i,
  output logic signed [psum_bw-1:0] sum_o
`ifdef MAC_TILE_SAT_EN
  ,output logic                     ovf_o
`endif
);

  // Operands widened to the full product width before multiplying so the
  // unsigned activation (zero-extended) and signed weight combine exactly.
  logic signed [2*bw:0] a_x, b_x, prod;

  assign a_x  = (2*bw+1)'($signed({1'b0, a_i}));
  assign b_x  = (2*bw+1)'(b_i);
  assign prod = a_x * b_x;

`ifdef MAC_TILE_SAT_EN
  localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  // One guard bit: overflow when the guard and sign bit disagree.
  logic signed [psum_bw:0] full;

  assign full  = (psum_bw+1)'(prod) + (psum_bw+1)'(c_i);
  assign ovf_o = full[psum_bw] ^ full[psum_bw-1];
  assign sum_o = !ovf_o ? full[psum_bw-1:0] : (full[psum_bw] ? SAT_MIN : SAT_MAX);
`else
  assign sum_o = psum_bw'(prod) + c_i;
`endif

endmodule

// File: rtl/mac_tile_dual.sv
// mac_tile_dual: systolic PE supporting weight-stationary (WS) and
// output-stationary (OS) dataflows.
//   clk, reset        rising-edge clock, async active-low reset
//   mode              0 = WS, 1 = OS, sampled in IDLE only
//   in_w / out_e      activation in from west, registered copy to east
//   inst_w / inst_e   {flush, execute, load} in, registered copy to east
//   in_n, valid_n     psum / weight / drain data from north
//   out_s, valid_s    registered result or forward to south
//   sat_flag          sticky saturation flag (only with MAC_TILE_SAT_EN)
// Build option MAC_TILE_SAT_EN: saturating arithmetic plus sat_flag port.
//
// state     | meaning
// IDLE      | no weight held; mode input is live
// WS_LOADED | WS weight latched in w_q, executes use it
// OS_ACC    | OS accumulation in progress in acc_q
// OS_DRAIN  | OS result sent, forwarding north data while flush is held
module mac_tile_dual
  import mac_tile_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  input  logic               valid_n,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s
`ifdef MAC_TILE_SAT_EN
  ,output logic              sat_flag
`endif
);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [bw-1:0]        w_q, w_d;
  logic [psum_bw-1:0]   acc_q, acc_d;
  logic [psum_bw-1:0]   out_s_q, out_s_d;
  logic                 valid_s_q, valid_s_d;
  logic [bw-1:0]        out_e_q;
  logic [2:0]           inst_e_q;

  logic                 do_flush, do_load, do_exec, os_sel;
  logic [bw-1:0]        mac_b;
  logic [psum_bw-1:0]   mac_c, mac_sum, w_fwd;

  // Strict priority decode: flush > load > execute.
  assign do_flush = inst_w[INST_FLUSH];
  assign do_load  = inst_w[INST_LOAD] & ~do_flush;
  assign do_exec  = inst_w[INST_EXEC] & ~do_flush & ~inst_w[INST_LOAD];

  // Mode is live in IDLE, latched everywhere else.
  assign os_sel = (state_q == IDLE) ? (mode == MODE_OS) : (mode_q == MODE_OS);

  assign w_fwd = psum_bw'($signed(in_n[bw-1:0]));

  // One multiplier-adder shared by both dataflows.
  assign mac_b = os_sel ? in_n[bw-1:0] : w_q;
  assign mac_c = os_sel ? acc_q : in_n;

`ifdef MAC_TILE_SAT_EN
  logic mac_ovf;
`endif

  mac_sat #(.bw(bw), .psum_bw(psum_bw)) u_mac (
    .a_i   (in_w),
    .b_i   (mac_b),
    .c_i   (mac_c),
    .sum_o (mac_sum)
`ifdef MAC_TILE_SAT_EN
    ,.ovf_o(mac_ovf)
`endif
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    w_d       = w_q;
    acc_d     = acc_q;
    out_s_d   = out_s_q;
    valid_s_d = 1'b0;
    if (state_q == IDLE) mode_d = mode;

    if (state_q == OS_DRAIN) begin
      if (do_flush) begin
        out_s_d   = in_n;
        valid_s_d = valid_n;
      end else begin
        state_d = IDLE;
      end
    end else if (os_sel) begin
      if (do_flush) begin
        out_s_d   = acc_q;
        valid_s_d = 1'b1;
        acc_d     = '0;
        state_d   = OS_DRAIN;
      end else if (do_exec) begin
        acc_d   = mac_sum;
        out_s_d = w_fwd;
        state_d = OS_ACC;
      end
    end else begin
      if (do_flush) begin
        w_d     = '0;
        state_d = IDLE;
      end else if (do_load) begin
        // Weight is one-shot: a second load while loaded is ignored.
        if (state_q == IDLE) begin
          w_d     = in_w;
          state_d = WS_LOADED;
        end
      end else if (do_exec) begin
        out_s_d   = mac_sum;
        valid_s_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_WS;
      w_q       <= '0;
      acc_q     <= '0;
      out_s_q   <= '0;
      valid_s_q <= 1'b0;
      out_e_q   <= '0;
      inst_e_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      acc_q     <= acc_d;
      out_s_q   <= out_s_d;
      valid_s_q <= valid_s_d;
      out_e_q   <= in_w;
      inst_e_q  <= inst_w;
    end
  end

`ifdef MAC_TILE_SAT_EN
  // The flush that drains an OS result keeps the flag so it travels with that
  // result; any other flush clears it.
  logic sat_q;
  logic enter_drain;

  assign enter_drain = do_flush & os_sel & (state_q != OS_DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sat_q <= 1'b0;
    else if (do_flush && !enter_drain)
      sat_q <= 1'b0;
    else if (do_exec && state_q != OS_DRAIN && mac_ovf)
      sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`endif

  assign out_s   = out_s_q;
  assign valid_s = valid_s_q;
  assign out_e   = out_e_q;
  assign inst_e  = inst_e_q;

endmodule

// File: tb/tb_mac_tile_dual.sv
module tb_mac_tile_dual;

  localparam int BW   = 4;
  localparam int PSUM = 16;

  logic            clk;
  logic            reset;
  logic            mode;
  logic [BW-1:0]   in_w;
  logic [BW-1:0]   out_e;
  logic [2:0]      inst_w;
  logic [2:0]      inst_e;
  logic [PSUM-1:0] in_n;
  logic            valid_n;
  logic [PSUM-1:0] out_s;
  logic            valid_s;
`ifdef MAC_TILE_SAT_EN
  logic            sat_flag;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] I_NONE  = 3'b000;
  localparam logic [2:0] I_LOAD  = 3'b001;
  localparam logic [2:0] I_EXEC  = 3'b010;
  localparam logic [2:0] I_FLUSH = 3'b100;

  mac_tile_dual #(.bw(BW), .psum_bw(PSUM)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .in_w    (in_w),
    .out_e   (out_e),
    .inst_w  (inst_w),
    .inst_e  (inst_e),
    .in_n    (in_n),
    .valid_n (valid_n),
    .out_s   (out_s),
    .valid_s (valid_s)
`ifdef MAC_TILE_SAT_EN
    ,.sat_flag(sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] inst, input logic [BW-1:0] a, input logic [PSUM-1:0] n);
    inst_w = inst;
    in_w   = a;
    in_n   = n;
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; valid_n = 1'b0;
    drive(I_NONE, '0, '0);
    step();
    chk("rst_out_s",   32'(out_s),   32'h0);
    chk("rst_valid_s", 32'(valid_s), 32'h0);
    chk("rst_out_e",   32'(out_e),   32'h0);
    chk("rst_inst_e",  32'(inst_e),  32'h0);
    @(negedge clk);
    reset = 1'b1;

    // WS basic: weight 3, then 5*3 + 10
    drive(I_LOAD, 4'd3, 16'd0); step();
    chk("ws_load_out_e",  32'(out_e),   32'd3);
    chk("ws_load_inst_e", 32'(inst_e),  32'(I_LOAD));
    chk("ws_load_valid",  32'(valid_s), 32'd0);
    drive(I_EXEC, 4'd5, 16'd10); step();
    chk("ws_basic_out_s", 32'(out_s),   32'd25);
    chk("ws_basic_valid", 32'(valid_s), 32'd1);
    chk("ws_basic_out_e", 32'(out_e),   32'd5);
    chk("ws_basic_inst_e", 32'(inst_e), 32'(I_EXEC));

    // One-shot: second load ignored, weight stays 3
    drive(I_LOAD, 4'd7, 16'd0); step();
    chk("ws_reload_valid", 32'(valid_s), 32'd0);
    chk("ws_reload_hold",  32'(out_s),   32'd25);
    drive(I_EXEC, 4'd2, 16'd0); step();
    chk("ws_oneshot_out_s", 32'(out_s), 32'd6);

    // Rearm and load 7
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("ws_flush_valid", 32'(valid_s), 32'd0);
    drive(I_LOAD, 4'd7, 16'd0); step();
    drive(I_EXEC, 4'd2, 16'd0); step();
    chk("ws_rearm_out_s", 32'(out_s), 32'd14);

    // Negative weight -2: 100 + 15*(-2)
    drive(I_FLUSH, 4'd0, 16'd0); step();
    drive(I_LOAD, 4'b1110, 16'd0); step();
    drive(I_EXEC, 4'd15, 16'd100); step();
    chk("ws_neg_out_s", 32'(out_s),   32'd70);
    chk("ws_neg_valid", 32'(valid_s), 32'd1);

    // Execute in IDLE uses zero weight
    drive(I_FLUSH, 4'd0, 16'd0); step();
    drive(I_EXEC, 4'd9, 16'h0055); step();
    chk("ws_idle_exec", 32'(out_s), 32'h55);

    // OS accumulate: 1*2 + 2*3 + 3*(-1) + 4*1 = 9
    mode = 1'b1;
    drive(I_EXEC, 4'd1, 16'd2); step();
    chk("os_fwd0",  32'(out_s),   32'd2);
    chk("os_val0",  32'(valid_s), 32'd0);
    drive(I_EXEC, 4'd2, 16'd3); step();
    drive(I_EXEC, 4'd3, 16'h000F); step();
    chk("os_fwd_neg", 32'(out_s), 32'hFFFF);
    drive(I_EXEC, 4'd4, 16'd1); step();
    chk("os_fwd3",  32'(out_s), 32'd1);
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("os_drain_out_s", 32'(out_s),   32'd9);
    chk("os_drain_valid", 32'(valid_s), 32'd1);
    drive(I_FLUSH, 4'd0, 16'h1234); valid_n = 1'b1; step();
    chk("os_fwd_out_s", 32'(out_s),   32'h1234);
    chk("os_fwd_valid", 32'(valid_s), 32'd1);
    valid_n = 1'b0;
    drive(I_NONE, 4'd0, 16'd0); step();
    chk("os_exit_valid", 32'(valid_s), 32'd0);
    chk("os_exit_hold",  32'(out_s),   32'h1234);

    // New accumulation from 0; mode change mid-accumulation ignored
    drive(I_EXEC, 4'd2, 16'd3); step();
    mode = 1'b0;
    drive(I_EXEC, 4'd1, 16'd1); step();
    chk("os_latched_fwd",   32'(out_s),   32'd1);
    chk("os_latched_valid", 32'(valid_s), 32'd0);
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("os_restart_acc", 32'(out_s), 32'd7);
    drive(I_NONE, 4'd0, 16'd0); step();

    // Saturation: 312 * 105 = 32760, then one more 105
    mode = 1'b1;
    for (int i = 0; i < 312; i++) begin
      drive(I_EXEC, 4'd15, 16'd7); step();
    end
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("sat_preset", 32'(out_s), 32'd32760);
    drive(I_NONE, 4'd0, 16'd0); step();
    for (int i = 0; i < 312; i++) begin
      drive(I_EXEC, 4'd15, 16'd7); step();
    end
    drive(I_EXEC, 4'd15, 16'd7); step();
    drive(I_FLUSH, 4'd0, 16'd0); step();
`ifdef MAC_TILE_SAT_EN
    chk("sat_clamp", 32'(out_s),    32'h7FFF);
    chk("sat_flag",  32'(sat_flag), 32'd1);
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("sat_flag_clr", 32'(sat_flag), 32'd0);
`else
    chk("sat_wrap", 32'(out_s), 32'h8061);
`endif
    drive(I_NONE, 4'd0, 16'd0); step();

    // Reset mid-accumulation (acc = 9)
    drive(I_EXEC, 4'd1, 16'd2); step();
    drive(I_EXEC, 4'd2, 16'd3); step();
    drive(I_EXEC, 4'd3, 16'h000F); step();
    drive(I_EXEC, 4'd4, 16'd1); step();
    chk("pre_rst_out_e", 32'(out_e), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_out_s",   32'(out_s),   32'h0);
    chk("async_valid",   32'(valid_s), 32'h0);
    chk("async_out_e",   32'(out_e),   32'h0);
    chk("async_inst_e",  32'(inst_e),  32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(I_FLUSH, 4'd0, 16'd0); step();
    chk("post_rst_acc",   32'(out_s),   32'h0);
    chk("post_rst_valid", 32'(valid_s), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_tile_dual.md
# mac_tile_dual

Parametrised, dual-dataflow processing element for the systolic MAC array. One tile supports two modes. In weight-stationary (WS) mode it holds one latched weight and adds its product into the partial sum flowing north-to-south. In output-stationary (OS) mode it accumulates locally from activations streaming east and weights streaming south, then drains its result down the column. Activations and instructions forward east with one-cycle registration, so tiles chain in rows exactly as the current single-mode tile does.

## Interface
- bw, 4, activation/weight width (activation unsigned, weight two's-complement)
- psum_bw, 16, partial-sum/accumulator width (signed), must be ≥ 2*bw+1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- mode  in  1  0 = WS, 1 = OS; sampled only in IDLE
- in_w  in  bw  activation from west
- out_e  out  bw  registered activation to east
- inst_w  in  3  [0] load, [1] execute, [2] flush/rearm
- inst_e  out  3  registered inst_w to east
- in_n  in  psum_bw  WS: psum from north; OS accumulate: weight in [bw-1:0]; OS drain: psum from north
- valid_n  in  1  qualifies in_n during OS drain
- out_s  out  psum_bw  registered result/forward to south
- valid_s  out  1  out_s carries a result

## Operation
- States: IDLE, WS_LOADED, OS_ACC, OS_DRAIN. Mode is latched on leaving IDLE.
- Forwarding in every state: out_e <= in_w, inst_e <= inst_w.
- Instruction priority: flush > load > execute. Lower-priority bits are ignored that cycle.
- WS mode, IDLE:
  - load: w_q <= in_w, go to WS_LOADED.
  - execute: out_s <= in_n + in_w*w_q with w_q = 0, valid_s <= 1.
- WS mode, WS_LOADED:
  - load: ignored; weight is one-shot.
  - execute: out_s <= in_n + in_w*w_q, valid_s <= 1.
  - flush: rearm; w_q <= 0, go to IDLE.
- OS mode, IDLE or OS_ACC:
  - execute: acc <= acc + in_w*in_n[bw-1:0], out_s <= sign-extended in_n[bw-1:0] (weight forwarded south), valid_s <= 0, state OS_ACC.
  - load: no-op.
- OS mode, flush from OS_ACC or IDLE: out_s <= acc, valid_s <= 1, acc <= 0, go to OS_DRAIN.
- OS_DRAIN:
  - While flush is held: out_s <= in_n, valid_s <= valid_n.
  - On flush deassert: go to IDLE, valid_s <= 0.
- Arithmetic:
  - Product is signed(0,in_w) × signed weight, sign-extended to psum_bw.
  - Sum wraps modulo 2^psum_bw unless saturation is enabled (see Configuration).
- Default when no valid instruction: valid_s <= 0, out_s holds.

## Timing
- All outputs are registered. Response appears one cycle after the edge at which inputs are sampled.
- Reset values: out_e = 0, inst_e = 0, out_s = 0, valid_s = 0, w_q = 0, acc = 0, state = IDLE.
- Reset assertion mid-execute or mid-drain clears immediately and asynchronously. Release is synchronous to the next clk edge.
- A mode change outside IDLE has no effect until the next return to IDLE.
- Back-to-back execute issues one result per cycle. There is no bubble between an OS flush and the first drain forward.
- The first cycle after an OS_DRAIN → IDLE transition may carry execute, which starts a new accumulation from acc = 0.

## Configuration
- MAC_TILE_SAT_EN defined:
  - WS add and OS accumulate saturate to [−2^(psum_bw−1), 2^(psum_bw−1)−1].
  - Sticky output sat_flag (1 bit, cleared by reset or flush) is added to the port list.
- Undefined: wrap-around arithmetic, no sat_flag port.

## Structure
- Package mac_tile_pkg:
  - state enum
  - inst bit indices (INST_LOAD = 0, INST_EXEC = 1, INST_FLUSH = 2)
  - mode encodings (MODE_WS, MODE_OS)
- Sub-module mac_sat (params bw, psum_bw):
  - combinational a*b + c with optional saturation under MAC_TILE_SAT_EN
  - instantiated once and shared by both modes

## Test plan
Setup: bw = 4, psum_bw = 16.
- WS basic: load in_w = 3, then execute in_w = 5, in_n = 10 → next cycle out_s = 25, valid_s = 1. out_e and inst_e follow inputs by 1 cycle.
- WS one-shot/rearm:
  - After weight 3, load in_w = 7 then execute in_w = 2, in_n = 0 → out_s = 6.
  - Flush, load 7, execute in_w = 2 → out_s = 14.
- Negative weight: WS load in_w = 4'b1110 (−2), execute in_w = 15, in_n = 100 → out_s = 70.
- OS accumulate/drain:
  - 4 executes (in_w, weight) = (1,2), (2,3), (3,−1), (4,1) → flush gives out_s = 9, valid_s = 1.
  - Next cycle forwards in_n = 0x1234 with valid_n = 1 → out_s = 0x1234, valid_s = 1.
- Saturation:
  - OS acc preset to 32760 via repeated executes, then execute (15,7).
  - With MAC_TILE_SAT_EN: flush gives 32767, sat_flag = 1.
  - Without: 32760 + 105 wraps to −32671.
- Reset mid-operation: assert reset during OS_ACC with acc = 9 → all outputs 0 immediately. After release, flush yields out_s = 0.
